// File: rtl/mem_access_unit_if.sv
// Memory bus between the access unit (master) and memory (slave).
// The master holds mem_req until mem_ack, and mem_ack is only meaningful while mem_req is high.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: aligns store lanes, extracts and extends load data, times out slow acks.
// Latency is 3 cycles with an immediate ack. The pipeline is held through stall while an access is in flight.
`ifndef MEM_LOAD
`define MEM_LOAD 2'b01
`endif
`ifndef MEM_STOR
`define MEM_STOR 2'b10
`endif
`ifndef SZ_FULL
`define SZ_FULL 3'd0
`endif
`ifndef SZ_HALF
`define SZ_HALF 3'd1
`endif
`ifndef SZ_BYTE
`define SZ_BYTE 3'd2
`endif

module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [31:0]         rt_value,
    input  logic [1:0]          mem_type,
    input  logic [2:0]          mem_size,
    input  logic                mem_signed,
    mem_access_unit_if.master   bus,
    output logic [31:0]         result,
    output logic                stall,
    output logic                out_valid,
    output logic                addr_err,
    output logic                bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state;
    logic [9:0]  wait_cnt;
    logic [31:0] res_q;
    logic        ld_q, half_q, byte_q, signed_q;

    logic        is_load, is_stor, is_half, is_byte, aligned, accept;
    logic [31:0] addr32;
    logic [3:0]  lane_wen;
    logic [31:0] lane_wdata;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ld_data;

    generate
        if (ADDR_W >= 32) begin : g_addr_trunc
            assign addr32 = address[31:0];
        end else begin : g_addr_ext
            assign addr32 = {{(32-ADDR_W){1'b0}}, address};
        end
    endgenerate

    // Sizes other than half/byte fall back to full-word behaviour.
    assign is_load = (mem_type == `MEM_LOAD);
    assign is_stor = (mem_type == `MEM_STOR);
    assign is_half = (mem_size == `SZ_HALF);
    assign is_byte = (mem_size == `SZ_BYTE);
    assign aligned = is_byte || (is_half ? !address[0] : (address[1:0] == 2'b00));
    assign accept  = (state == IDLE) && in_valid && (is_load || is_stor) && aligned;

    always_comb begin
        lane_wen   = 4'b1111;
        lane_wdata = rt_value;
        if (is_half) begin
            lane_wen   = address[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{rt_value[15:0]}};
        end else if (is_byte) begin
            lane_wen   = 4'b0001 << address[1:0];
            lane_wdata = {4{rt_value[7:0]}};
        end
    end

    // Lane selection uses the registered address so extraction does not depend on pipeline inputs.
    always_comb begin
        ld_half = bus.mem_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (bus.mem_addr[1:0])
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_data = bus.mem_rdata;
        if (half_q)
            ld_data = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
        else if (byte_q)
            ld_data = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h000000, ld_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            res_q         <= '0;
            bus_err       <= 1'b0;
            ld_q          <= 1'b0;
            half_q        <= 1'b0;
            byte_q        <= 1'b0;
            signed_q      <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_wen   <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (accept) begin
                        state         <= REQ;
                        wait_cnt      <= '0;
                        ld_q          <= is_load;
                        half_q        <= is_half;
                        byte_q        <= is_byte;
                        signed_q      <= mem_signed;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= address;
                        bus.mem_wen   <= is_stor ? lane_wen : 4'b0000;
                        bus.mem_wdata <= lane_wdata;
                    end
                end
                REQ: begin
                    // An ack in the final wait cycle still completes the access normally.
                    if (bus.mem_ack) begin
                        state       <= RESP;
                        res_q       <= ld_q ? ld_data : addr32;
                        bus.mem_req <= 1'b0;
                        bus.mem_wen <= '0;
                    end else if (wait_cnt == 10'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        res_q       <= '0;
                        bus_err     <= 1'b1;
                        bus.mem_req <= 1'b0;
                        bus.mem_wen <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    bus_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall     = 1'b0;
        out_valid = 1'b0;
        addr_err  = 1'b0;
        result    = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stall     = accept;
                    out_valid = in_valid && !accept;
                    addr_err  = in_valid && (is_load || is_stor) && !aligned;
                    if (in_valid && !accept)
                        result = addr32;
                end
                REQ:  stall = 1'b1;
                RESP: begin
                    out_valid = 1'b1;
                    result    = res_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32: width of address, result passthrough and mem_addr.
REQ-002 Parameter TIMEOUT, default 64: maximum wait cycles for mem_ack before bus error, range 1..1023.
REQ-003 Port clk  in  1: single clock, all state updates on rising edge.
REQ-004 Port rst  in  1: reset, synchronous, active-high.
REQ-005 Port in_valid  in  1: pipeline presents an instruction this cycle.
REQ-006 Port address  in  ADDR_W: effective address, or ALU result for non-memory ops.
REQ-007 Port rt_value  in  32: store data.
REQ-008 Port mem_type  in  2: encoding `MEM_LOAD / `MEM_STOR; any other value is non-memory.
REQ-009 Port mem_size  in  3: encoding `SZ_FULL / `SZ_HALF / `SZ_BYTE; other values are treated as `SZ_FULL.
REQ-010 Port mem_signed  in  1: 1 = sign-extend load, 0 = zero-extend.
REQ-011 Port mem_req  out  1: bus request, held until mem_ack or timeout.
REQ-012 Port mem_wen  out  4: byte-lane write enables, 0 for loads.
REQ-013 Port mem_addr  out  ADDR_W: registered access address.
REQ-014 Port mem_wdata  out  32: registered, lane-replicated store data.
REQ-015 Port mem_rdata  in  32: read data, valid in mem_ack cycle.
REQ-016 Port mem_ack  in  1: access complete; variable latency, ignored unless mem_req=1.
REQ-017 Port result  out  32: load data or address passthrough.
REQ-018 Port stall  out  1: pipeline holds all inputs stable while 1.
REQ-019 Port out_valid  out  1: result valid this cycle.
REQ-020 Port addr_err  out  1: misaligned access, combinational.
REQ-021 Port bus_err  out  1: access timed out, one-cycle pulse.

Function
REQ-022 FSM states IDLE, REQ, RESP.
REQ-023 Access is accepted in IDLE when in_valid=1, mem_type is load/store and address is aligned; aligned = half: address[0]=0, full: address[1:0]=0.
REQ-024 Misaligned load/store in IDLE: addr_err=1 same cycle, no mem_req, stall=0, out_valid=1, result=address, FSM stays IDLE.
REQ-025 Non-memory op in IDLE with in_valid=1: result=address, out_valid=1, stall=0, no state change.
REQ-026 On accept: stall=1 combinationally; mem_addr, mem_wen and mem_wdata are registered; FSM goes to REQ; wait counter is cleared.
REQ-027 REQ: mem_req=1, stall=1; counter increments each cycle without mem_ack.
REQ-028 REQ with mem_ack=1: loads register the extracted result; next state is RESP; mem_req=0 from the next cycle.
REQ-029 REQ with counter=TIMEOUT-1 and mem_ack=0: next state is RESP with bus_err pulse, result=0, mem_req=0; a late mem_ack is ignored.
REQ-030 mem_ack and timeout in the same cycle: mem_ack wins, no bus_err.
REQ-031 RESP: stall=0, out_valid=1, result=registered value; no new accept (inputs still belong to the finished instruction); next state is IDLE.
REQ-032 Latency: load/store with ack in the first REQ cycle = 3 cycles (accept, REQ, RESP).
REQ-033 Store lanes: FULL wen=1111 with wdata=rt_value; HALF wdata={2{rt[15:0]}}, wen=1100 if address[1] else 0011; BYTE wdata={4{rt[7:0]}}, wen=one-hot 1<<address[1:0].
REQ-034 Load extract: HALF takes lane address[1]; BYTE takes lane address[1:0]; the selected lane is extended per mem_signed to 32 bits; FULL takes mem_rdata unmodified.
REQ-035 Store completion: result=address in RESP.

Reset
REQ-036 rst=1: FSM goes to IDLE, counter=0, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, registered result=0, bus_err=0, next cycle.
REQ-037 rst=1 in REQ abandons the access; mem_req=0 the following cycle; a subsequent mem_ack is ignored.
REQ-038 out_valid, stall and addr_err are 0 during reset cycles regardless of inputs.

Verification
REQ-039 LB address=0x1003, mem_signed=1, rdata=0x80FF_0000, ack after 2 cycles -> result=0xFFFF_FF80, stall=1 for 3 cycles, then out_valid=1.
REQ-040 SH address=0x2002, rt=0x1234_ABCD, ack immediate -> mem_wen=1100, mem_wdata=0xABCD_ABCD, result=0x2002 in RESP.
REQ-041 LW address=0x0006 -> addr_err=1, mem_req never asserted, result=0x0006, stall=0.
REQ-042 LHU with mem_ack never asserted, TIMEOUT=4 -> mem_req high for exactly 4 cycles, bus_err=1 for one cycle, result=0.
REQ-043 Ack and timeout coincide at TIMEOUT-1 -> result=extracted data, bus_err=0.
REQ-044 rst asserted in the second REQ cycle, then mem_ack -> mem_req=0 after reset, FSM in IDLE, out_valid stays 0.
